// File: rtl/diag_event_detector_if.sv
// Commit-side, config and event-side signals of the diagnosis PC event detector.
// master = core/config/FIFO side, slave = detector.
`ifndef DIAGNOSIS_EV_ID_WIDTH
`define DIAGNOSIS_EV_ID_WIDTH 4
`endif
`ifndef DIAGNOSIS_TIMESTAMP_WIDTH
`define DIAGNOSIS_TIMESTAMP_WIDTH 32
`endif

interface diag_event_detector_if #(
    parameter int NUM_EVENTS = 8,
    parameter int ID_WIDTH   = `DIAGNOSIS_EV_ID_WIDTH,
    parameter int TIME_WIDTH = `DIAGNOSIS_TIMESTAMP_WIDTH,
    parameter int LOST_WIDTH = 16
);
    localparam int ADDR_WIDTH = $clog2(2*NUM_EVENTS) + 1;

    logic                  wb_valid;
    logic [31:0]           wb_pc;
    logic                  cfg_we;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [31:0]           cfg_wdata;
    logic                  ev_valid;
    logic [ID_WIDTH-1:0]   ev_id;
    logic [TIME_WIDTH-1:0] ev_time;
    logic                  ev_ready;
    logic [LOST_WIDTH-1:0] lost_count;

    modport master (
        output wb_valid, wb_pc, cfg_we, cfg_addr, cfg_wdata, ev_ready,
        input  ev_valid, ev_id, ev_time, lost_count
    );

    modport slave (
        input  wb_valid, wb_pc, cfg_we, cfg_addr, cfg_wdata, ev_ready,
        output ev_valid, ev_id, ev_time, lost_count
    );
endinterface

// File: rtl/diag_event_detector.sv
// Matches committed PCs against a config table and emits one timestamped event per hit.
// Latency 1 cycle; push-only: beats with ev_ready low are dropped and counted in lost_count.
`ifndef DIAGNOSIS_EV_ID_WIDTH
`define DIAGNOSIS_EV_ID_WIDTH 4
`endif
`ifndef DIAGNOSIS_TIMESTAMP_WIDTH
`define DIAGNOSIS_TIMESTAMP_WIDTH 32
`endif

module diag_event_detector #(
    parameter int NUM_EVENTS = 8,
    parameter int ID_WIDTH   = `DIAGNOSIS_EV_ID_WIDTH,
    parameter int TIME_WIDTH = `DIAGNOSIS_TIMESTAMP_WIDTH,
    parameter int LOST_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    diag_event_detector_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(2*NUM_EVENTS) + 1;
    localparam logic [ADDR_WIDTH-1:0] GLOBAL_ADDR = ADDR_WIDTH'(2*NUM_EVENTS);

    if (NUM_EVENTS + 1 > 2**ID_WIDTH) begin : g_bad_params
        $error("ID_WIDTH too narrow for NUM_EVENTS plus reserved ID 0");
    end

    logic [TIME_WIDTH-1:0] ts_q, ts_d;
    logic [31:0]           pc_q [NUM_EVENTS];
    logic [31:0]           pc_d [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] en_q, en_d;
    logic                  gen_q, gen_d;
    logic                  lost_clr;
    logic [LOST_WIDTH-1:0] lost_q, lost_d;
    logic [NUM_EVENTS-1:0] hit;
    logic                  hit_any;
    logic [ID_WIDTH-1:0]   win_id;
    logic                  ev_valid_q, ev_valid_d;
    logic [ID_WIDTH-1:0]   ev_id_q, ev_id_d;
    logic [TIME_WIDTH-1:0] ev_time_q, ev_time_d;

    // Config decode; the table registers update at the edge, so same-cycle compares see old values.
    always_comb begin
        pc_d     = pc_q;
        en_d     = en_q;
        gen_d    = gen_q;
        lost_clr = 1'b0;
        if (bus.cfg_we) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (bus.cfg_addr == ADDR_WIDTH'(2*i))     pc_d[i] = bus.cfg_wdata;
                if (bus.cfg_addr == ADDR_WIDTH'(2*i + 1)) en_d[i] = bus.cfg_wdata[0];
            end
            if (bus.cfg_addr == GLOBAL_ADDR) begin
                gen_d    = bus.cfg_wdata[0];
                lost_clr = bus.cfg_wdata[1];
            end
        end
    end

    // Scan from the top down so the lowest matching index is the one left in win_id.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        win_id  = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            hit[i] = bus.wb_valid & gen_q & en_q[i] & (bus.wb_pc == pc_q[i]);
            if (hit[i]) begin
                hit_any = 1'b1;
                win_id  = ID_WIDTH'(i + 1);
            end
        end
    end

    always_comb begin
        ts_d       = ts_q + TIME_WIDTH'(1);
        ev_valid_d = hit_any;
        ev_id_d    = hit_any ? win_id : ev_id_q;
        ev_time_d  = hit_any ? ts_q   : ev_time_q;
        lost_d     = lost_q;
        if (lost_clr) begin
            lost_d = '0;
        end else if (ev_valid_q && !bus.ev_ready && (lost_q != '1)) begin
            lost_d = lost_q + LOST_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            en_q       <= '0;
            gen_q      <= 1'b0;
            lost_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_time_q  <= '0;
            for (int i = 0; i < NUM_EVENTS; i++) pc_q[i] <= '0;
        end else begin
            ts_q       <= ts_d;
            en_q       <= en_d;
            gen_q      <= gen_d;
            lost_q     <= lost_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_time_q  <= ev_time_d;
            for (int i = 0; i < NUM_EVENTS; i++) pc_q[i] <= pc_d[i];
        end
    end

    assign bus.ev_valid   = ev_valid_q;
    assign bus.ev_id      = ev_id_q;
    assign bus.ev_time    = ev_time_q;
    assign bus.lost_count = lost_q;
endmodule

// File: tb/tb_diag_event_detector.sv
// Directed bench: stimulus pushes expected events into a queue, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_diag_event_detector;
    localparam int NE = 8;
    localparam int IW = 4;
    localparam int TW = 8;
    localparam int LW = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] tm;
    } ev_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    ev_t  exp_q [$];
    logic [TW-1:0] tb_ts;

    diag_event_detector_if #(.NUM_EVENTS(NE), .ID_WIDTH(IW), .TIME_WIDTH(TW), .LOST_WIDTH(LW)) bus ();

    diag_event_detector #(.NUM_EVENTS(NE), .ID_WIDTH(IW), .TIME_WIDTH(TW), .LOST_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: zero in reset, +1 per clock afterwards.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ev_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got id=%0d time=%0d expected no beat", bus.ev_id, bus.ev_time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_id", 32'(bus.ev_id), 32'(e.id));
                check("ev_time", 32'(bus.ev_time), 32'(e.tm));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input int id, input int tm);
        ev_t e;
        e.id = IW'(id);
        e.tm = TW'(tm);
        exp_q.push_back(e);
    endtask

    task automatic commit(input logic [31:0] pc);
        bus.wb_valid = 1'b1;
        bus.wb_pc    = pc;
        step();
        bus.wb_valid = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'(addr);
        bus.cfg_wdata = data;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic wait_ts(input int v);
        int guard = 0;
        while (tb_ts != TW'(v) && guard < 600) begin
            step();
            guard++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_ev_valid"}, 32'(bus.ev_valid), 32'd0);
        check({tag, "_ev_id"}, 32'(bus.ev_id), 32'd0);
        check({tag, "_ev_time"}, 32'(bus.ev_time), 32'd0);
        check({tag, "_lost"}, 32'(bus.lost_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_pc     = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.ev_ready  = 1'b1;
        repeat (2) @(posedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();

        // Entry 2 at 0x100, global enable; hit at counter 37.
        cfg_write(4, 32'h100);
        cfg_write(5, 32'h1);
        cfg_write(16, 32'h1);
        wait_ts(37);
        exp_push(3, 37);
        commit(32'h100);
        step();
        @(negedge clk);
        check("pulse_single_cycle", 32'(bus.ev_valid), 32'd0);
        step();

        // Disable in the same cycle as a commit: that commit still matches, the next one does not.
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'd16;
        bus.cfg_wdata = 32'h0;
        exp_push(3, int'(tb_ts));
        commit(32'h100);
        bus.cfg_we = 1'b0;
        commit(32'h100);
        cfg_write(16, 32'h1);

        // Entries 1 and 4 share a PC: lowest index wins.
        cfg_write(2, 32'h200);
        cfg_write(3, 32'h1);
        cfg_write(8, 32'h200);
        cfg_write(9, 32'h1);
        exp_push(2, int'(tb_ts));
        commit(32'h200);
        step();

        // Back-to-back commits.
        for (int k = 0; k < 3; k++) begin
            exp_push(3, int'(tb_ts));
            commit(32'h100);
        end
        step();

        // Drops with ev_ready low.
        bus.ev_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_push(3, int'(tb_ts));
            commit(32'h100);
        end
        step();
        step();
        @(negedge clk);
        check("lost_after_5", 32'(bus.lost_count), 32'd5);
        step();
        exp_push(3, int'(tb_ts));
        commit(32'h100);
        cfg_write(16, 32'h3);
        @(negedge clk);
        check("lost_clear_priority", 32'(bus.lost_count), 32'd0);
        step();
        for (int k = 0; k < 20; k++) begin
            exp_push(3, int'(tb_ts));
            commit(32'h100);
        end
        step();
        step();
        @(negedge clk);
        check("lost_saturate", 32'(bus.lost_count), 32'd15);
        step();
        bus.ev_ready = 1'b1;
        step();
        @(negedge clk);
        check("lost_hold_when_ready", 32'(bus.lost_count), 32'd15);
        step();

        // Timestamp wrap.
        wait_ts(255);
        exp_push(3, 255);
        commit(32'h100);
        exp_push(3, 0);
        commit(32'h100);
        step();

        // Reset with a beat sitting in the output register.
        commit(32'h100);
        rst_n = 1'b0;
        check_idle_outputs("midreset");
        step();
        rst_n = 1'b1;
        step();
        commit(32'h100);
        commit(32'h100);
        step();
        @(negedge clk);
        check("post_reset_no_event_id", 32'(bus.ev_id), 32'd0);
        step();
        cfg_write(4, 32'h100);
        cfg_write(5, 32'h1);
        cfg_write(16, 32'h1);
        exp_push(3, int'(tb_ts));
        commit(32'h100);
        repeat (3) step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
